// File: rtl/rle_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rle_seq_pkg
//  Description : Shared types and constants for the RLE block sequencer:
//                sequencer state encoding, default widths, the sideband tag
//                width and the 8x8 zigzag scan table (scan index -> raster
//                index).
//  Revision    : 1.0 - initial release
// ============================================================================
package rle_seq_pkg;

  localparam int DEF_COEFF_W   = 12;
  localparam int DEF_SLOT_BITS = 6;

  // Sideband carried alongside each coefficient: {sob, last, eof}
  localparam int TAG_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // ZIGZAG[k] is the raster position (row*8 + col) of scan index k.
  localparam logic [5:0] ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage
`default_nettype wire

// File: rtl/rle_seq_skid.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rle_seq_skid
//  Description : Two-entry FIFO holding returned coefficient reads and their
//                tags. Entry 0 is the head register that directly drives the
//                output stream, so the stream is glitch-free and registered.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                push, data, tags- write one entry (data + sideband tags)
//                pop             - remove the head (ignored when empty)
//                flush           - discard all entries (wins over push/pop)
//                valid, head     - head present / head contents {tags, data}
//                count           - number of entries held (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module rle_seq_skid
  import rle_seq_pkg::*;
#(
  parameter int DATA_W = DEF_COEFF_W,
  parameter int TAGS_W = TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        data,
  input  logic [TAGS_W-1:0]        tags,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     valid,
  output logic [TAGS_W+DATA_W-1:0] head,
  output logic [1:0]               count
);

  localparam int ENTRY_W = TAGS_W + DATA_W;

  logic [ENTRY_W-1:0] entry0_q, entry0_d;
  logic [ENTRY_W-1:0] entry1_q, entry1_d;
  logic [1:0]         count_q, count_d;
  logic [ENTRY_W-1:0] push_entry;
  logic               pop_eff;
  logic               push_eff;

  always_comb begin
    push_entry = {tags, data};
    pop_eff    = pop && (count_q != 2'd0);
    // A push into a full FIFO is only legal when the head leaves this cycle.
    push_eff   = push && ((count_q != 2'd2) || pop_eff);
    entry0_d   = entry0_q;
    entry1_d   = entry1_q;
    count_d    = count_q;

    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push_eff, pop_eff})
        2'b10: begin
          if (count_q == 2'd0) begin
            entry0_d = push_entry;
          end else begin
            entry1_d = push_entry;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          entry0_d = entry1_q;
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new entry lands behind whatever remains.
          if (count_q == 2'd1) begin
            entry0_d = push_entry;
          end else begin
            entry0_d = entry1_q;
            entry1_d = push_entry;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign valid = (count_q != 2'd0);
  assign head  = entry0_q;
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/rle_block_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rle_block_sequencer
//  Description : Walks a run of 64-coefficient blocks held in a coefficient
//                buffer, reading each block in zigzag order and streaming the
//                coefficients (with start/end-of-block and end-of-run tags)
//                to the RLE core over a valid/ready handshake.
//  Ports       : ACLK, ARESET            - clock, async active-high reset
//                cfg_start/abort         - run start / cancel pulses
//                cfg_num_blocks          - blocks in run (sampled at start)
//                busy, done, blk_cnt     - run status
//                buf_rd_en/addr/data     - buffer read port (1-cycle latency)
//                m_valid/ready/coeff     - coefficient stream
//                m_sob, m_last, m_eof    - stream sideband, qualified by valid
//  Revision    : 1.0 - initial release
// ============================================================================
module rle_block_sequencer
  import rle_seq_pkg::*;
#(
  parameter int COEFF_W   = DEF_COEFF_W,
  parameter int SLOT_BITS = DEF_SLOT_BITS
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   cfg_start,
  input  logic                   cfg_abort,
  input  logic [15:0]            cfg_num_blocks,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            blk_cnt,
  output logic                   buf_rd_en,
  output logic [SLOT_BITS+5:0]   buf_rd_addr,
  input  logic [COEFF_W-1:0]     buf_rd_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [COEFF_W-1:0]     m_coeff,
  output logic                   m_sob,
  output logic                   m_last,
  output logic                   m_eof
);

  localparam int HEAD_W = TAG_W + COEFF_W;

  seq_state_t        state_q, state_d;
  logic [15:0]       num_blocks_q, num_blocks_d;
  logic [15:0]       blk_idx_q, blk_idx_d;
  logic [15:0]       blk_cnt_q, blk_cnt_d;
  logic [5:0]        zz_k_q, zz_k_d;
  logic              done_q, done_d;
  logic              rd_pend_q, rd_pend_d;
  logic [TAG_W-1:0]  rd_tags_q, rd_tags_d;
  // Low during the first edge after reset release so a start pulse
  // overlapping the release is not taken.
  logic              armed_q;

  logic              fifo_valid;
  logic [HEAD_W-1:0] fifo_head;
  logic [1:0]        fifo_count;
  logic [TAG_W-1:0]  head_tags;
  logic [COEFF_W-1:0] head_coeff;

  logic              handshake;
  logic [2:0]        occupancy;
  logic              can_issue;
  logic              last_k;
  logic              last_blk;
  logic              rd_en;
  logic [TAG_W-1:0]  issue_tags;

  assign head_tags  = fifo_head[HEAD_W-1:COEFF_W];
  assign head_coeff = fifo_head[COEFF_W-1:0];

  // Read issue logic
  always_comb begin
    handshake  = fifo_valid && m_ready;
    occupancy  = {1'b0, fifo_count} + {2'b00, rd_pend_q};
    // Entries held plus reads in flight must stay within the two FIFO slots;
    // a beat leaving this cycle frees its slot before the new data returns.
    can_issue  = (occupancy < 3'd2) || (handshake && (occupancy == 3'd2));
    last_k     = (zz_k_q == 6'd63);
    last_blk   = (blk_idx_q == (num_blocks_q - 16'd1));
    rd_en      = (state_q == ST_FETCH) && can_issue && !cfg_abort;
    issue_tags = {(zz_k_q == 6'd0), last_k, (last_k && last_blk)};
  end

  // Next-state and control
  always_comb begin
    state_d      = state_q;
    num_blocks_d = num_blocks_q;
    blk_idx_d    = blk_idx_q;
    zz_k_d       = zz_k_q;
    blk_cnt_d    = blk_cnt_q;
    done_d       = 1'b0;
    rd_pend_d    = rd_en;
    rd_tags_d    = rd_en ? issue_tags : rd_tags_q;

    // head_tags[1] is the end-of-block tag
    if (handshake && head_tags[1]) begin
      blk_cnt_d = blk_cnt_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_start && armed_q) begin
          num_blocks_d = cfg_num_blocks;
          blk_idx_d    = 16'd0;
          zz_k_d       = 6'd0;
          blk_cnt_d    = 16'd0;
          state_d      = (cfg_num_blocks == 16'd0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (rd_en) begin
          zz_k_d = zz_k_q + 6'd1;
          if (last_k) begin
            blk_idx_d = blk_idx_q + 16'd1;
            if (last_blk) begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        if ((fifo_count == 2'd0) && !rd_pend_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // done is registered, so the pulse appears as the FSM returns to IDLE
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (cfg_abort) begin
      state_d   = ST_IDLE;
      rd_pend_d = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      num_blocks_q <= 16'd0;
      blk_idx_q    <= 16'd0;
      blk_cnt_q    <= 16'd0;
      zz_k_q       <= 6'd0;
      done_q       <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_tags_q    <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_blocks_q <= num_blocks_d;
      blk_idx_q    <= blk_idx_d;
      blk_cnt_q    <= blk_cnt_d;
      zz_k_q       <= zz_k_d;
      done_q       <= done_d;
      rd_pend_q    <= rd_pend_d;
      rd_tags_q    <= rd_tags_d;
      armed_q      <= 1'b1;
    end
  end

  // Returned read data enters the FIFO on the cycle it is valid; an abort
  // flushes the FIFO and drops any data returning in that same cycle.
  rle_seq_skid #(
    .DATA_W (COEFF_W),
    .TAGS_W (TAG_W)
  ) u_skid (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (rd_pend_q),
    .data  (buf_rd_data),
    .tags  (rd_tags_q),
    .pop   (handshake),
    .flush (cfg_abort),
    .valid (fifo_valid),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign blk_cnt     = blk_cnt_q;
  assign buf_rd_en   = rd_en;
  assign buf_rd_addr = {blk_idx_q[SLOT_BITS-1:0], ZIGZAG[zz_k_q]};
  assign m_valid     = fifo_valid;
  assign m_coeff     = head_coeff;
  assign m_sob       = fifo_valid && head_tags[2];
  assign m_last      = fifo_valid && head_tags[1];
  assign m_eof       = fifo_valid && head_tags[0];

endmodule
`default_nettype wire

// File: tb/tb_rle_block_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_rle_block_sequencer
//  Description : Self-checking bench for rle_block_sequencer. A registered
//                buffer model returns data equal to its address; expected
//                beats are queued when each run is started and compared as
//                the DUT hands them over. The zigzag order is generated here
//                by walking the anti-diagonals of the 8x8 block.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rle_block_sequencer;

  localparam int COEFF_W   = 12;
  localparam int SLOT_BITS = 6;
  localparam int AW        = SLOT_BITS + 6;

  logic               ACLK = 1'b0;
  logic               ARESET = 1'b1;
  logic               cfg_start = 1'b0;
  logic               cfg_abort = 1'b0;
  logic [15:0]        cfg_num_blocks = 16'd0;
  logic               busy;
  logic               done;
  logic [15:0]        blk_cnt;
  logic               buf_rd_en;
  logic [AW-1:0]      buf_rd_addr;
  logic [COEFF_W-1:0] buf_rd_data;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic [COEFF_W-1:0] m_coeff;
  logic               m_sob;
  logic               m_last;
  logic               m_eof;

  typedef logic [COEFF_W+2:0] beat_t;  // {coeff, sob, last, eof}

  int         n_checks   = 0;
  int         n_fail     = 0;
  int         beats_seen = 0;
  logic [5:0] zz [64];
  beat_t      exp_q [$];

  always #5 ACLK = ~ACLK;

  // Buffer model: one-cycle read latency, contents equal the address.
  always @(posedge ACLK) begin
    if (buf_rd_en) buf_rd_data <= COEFF_W'(buf_rd_addr);
  end

  rle_block_sequencer #(
    .COEFF_W   (COEFF_W),
    .SLOT_BITS (SLOT_BITS)
  ) dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .cfg_start      (cfg_start),
    .cfg_abort      (cfg_abort),
    .cfg_num_blocks (cfg_num_blocks),
    .busy           (busy),
    .done           (done),
    .blk_cnt        (blk_cnt),
    .buf_rd_en      (buf_rd_en),
    .buf_rd_addr    (buf_rd_addr),
    .buf_rd_data    (buf_rd_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_coeff        (m_coeff),
    .m_sob          (m_sob),
    .m_last         (m_last),
    .m_eof          (m_eof)
  );

  // Scoreboard: every accepted beat is compared against the queue head.
  always @(negedge ACLK) begin
    beat_t got;
    beat_t want;
    if (!ARESET && m_valid && m_ready) begin
      got = {m_coeff, m_sob, m_last, m_eof};
      beats_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra_beat: got {coeff,sob,last,eof}=%h, required no beat", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL sb_beat #%0d: got {coeff,sob,last,eof}=%h, required %h",
                   beats_seen, got, want);
        end
      end
    end
  end

  task automatic build_zigzag();
    int n;
    int lo;
    int hi;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if ((s % 2) == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[n] = 6'(r * 8 + (s - r)); n++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[n] = 6'(r * 8 + (s - r)); n++; end
      end
    end
  endtask

  task automatic push_expected(input int nblk);
    beat_t      e;
    logic [5:0] slot;
    for (int b = 0; b < nblk; b++) begin
      slot = b[SLOT_BITS-1:0];
      for (int k = 0; k < 64; k++) begin
        e = {slot, zz[k], (k == 0), (k == 63), (k == 63 && b == nblk - 1)};
        exp_q.push_back(e);
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle after start.
  task automatic start_run(input logic [15:0] n);
    cfg_num_blocks = n;
    cfg_start      = 1'b1;
    @(posedge ACLK); #1;
    cfg_start      = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1; m_ready = 1'b1; cfg_start = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, buf_rd_en, m_valid, m_sob, m_last, m_eof} !== 7'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, required 0000000",
                         {busy, done, buf_rd_en, m_valid, m_sob, m_last, m_eof});
    end
    repeat (2) @(posedge ACLK);
    #1;
    n_checks++;
    if (blk_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_blk_cnt: got %0d, required 0", blk_cnt); end
    n_checks++;
    if ({buf_rd_addr, m_coeff} !== '0) begin
      n_fail++; $display("FAIL reset_addr_coeff: got addr=%h coeff=%h, required 0", buf_rd_addr, m_coeff);
    end
    // Start held across the first edge after release must be ignored.
    ARESET = 1'b0; cfg_num_blocks = 16'd1; cfg_start = 1'b1;
    @(posedge ACLK); #1;
    cfg_start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL release_cycle_start: busy=%b, required 0", busy); end
    repeat (3) begin @(posedge ACLK); #1; end
    n_checks++;
    if ({busy, buf_rd_en, m_valid} !== 3'b000) begin
      n_fail++; $display("FAIL release_cycle_idle: {busy,rd_en,valid}=%b, required 000", {busy, buf_rd_en, m_valid});
    end
  endtask

  task automatic test_single_block();
    int first_valid, done_cyc, done_cnt, base;
    first_valid = -1; done_cyc = -1; done_cnt = 0;
    m_ready = 1'b1;
    push_expected(1);
    base = beats_seen;
    start_run(16'd1);
    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(negedge ACLK);
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      @(posedge ACLK); #1;
    end
    n_checks++;
    if (first_valid != 3) begin n_fail++; $display("FAIL single_first_valid: cycle %0d, required 3", first_valid); end
    // beats in cycles 3..66, FIFO empty in DRAIN at 67, DONE at 68, done at 69
    n_checks++;
    if (done_cyc != 69) begin n_fail++; $display("FAIL single_done_cycle: cycle %0d, required 69", done_cyc); end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL single_done_count: %0d pulses, required 1", done_cnt); end
    n_checks++;
    if (beats_seen - base != 64) begin n_fail++; $display("FAIL single_beats: got %0d, required 64", beats_seen - base); end
    n_checks++;
    if (blk_cnt !== 16'd1) begin n_fail++; $display("FAIL single_blk_cnt: got %0d, required 1", blk_cnt); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b, required 0", busy); end
  endtask

  task automatic test_zero_blocks();
    int done_cyc, done_cnt;
    logic busy_c1, valid_seen;
    done_cyc = -1; done_cnt = 0; busy_c1 = 1'b0; valid_seen = 1'b0;
    m_ready = 1'b1;
    start_run(16'd0);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge ACLK);
      if (cyc == 1) busy_c1 = busy;
      if (m_valid || buf_rd_en) valid_seen = 1'b1;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      @(posedge ACLK); #1;
    end
    n_checks++;
    if (busy_c1 !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %b in DONE, required 1", busy_c1); end
    n_checks++;
    if (done_cyc != 2) begin n_fail++; $display("FAIL zero_done_cycle: cycle %0d, required 2", done_cyc); end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_count: %0d pulses, required 1", done_cnt); end
    n_checks++;
    if (valid_seen !== 1'b0) begin n_fail++; $display("FAIL zero_activity: valid/rd seen=%b, required 0", valid_seen); end
    n_checks++;
    if (blk_cnt !== 16'd0) begin n_fail++; $display("FAIL zero_blk_cnt: got %0d, required 0", blk_cnt); end
  endtask

  task automatic test_random_ready();
    int    base, done_cnt;
    logic  held;
    beat_t held_beat, now_beat;
    done_cnt = 0; held = 1'b0; held_beat = '0;
    push_expected(3);
    base = beats_seen;
    m_ready = 1'($urandom_range(0, 1));
    start_run(16'd3);
    for (int cyc = 1; cyc <= 3000 && done_cnt == 0; cyc++) begin
      m_ready = 1'($urandom_range(0, 1));
      @(negedge ACLK);
      now_beat = {m_coeff, m_sob, m_last, m_eof};
      if (held) begin
        n_checks++;
        if (!m_valid || now_beat !== held_beat) begin
          n_fail++;
          $display("FAIL rand_hold_stable: valid=%b beat=%h, required valid=1 beat=%h", m_valid, now_beat, held_beat);
        end
      end
      held      = m_valid && !m_ready;
      held_beat = now_beat;
      if (done) done_cnt++;
      @(posedge ACLK); #1;
    end
    m_ready = 1'b1;
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL rand_done: %0d pulses within budget, required 1", done_cnt); end
    n_checks++;
    if (beats_seen - base != 192) begin n_fail++; $display("FAIL rand_beats: got %0d, required 192", beats_seen - base); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_leftover: %0d beats missing, required 0", exp_q.size()); end
    n_checks++;
    if (blk_cnt !== 16'd3) begin n_fail++; $display("FAIL rand_blk_cnt: got %0d, required 3", blk_cnt); end
  endtask

  task automatic test_abort();
    int   base, done_cnt;
    logic activity;
    m_ready = 1'b1;
    push_expected(2);
    base = beats_seen;
    start_run(16'd2);
    for (int cyc = 0; cyc < 200 && (beats_seen - base) < 20; cyc++) begin
      @(posedge ACLK); #1;
    end
    n_checks++;
    if (beats_seen - base != 20) begin n_fail++; $display("FAIL abort_prefix: got %0d beats, required 20", beats_seen - base); end
    m_ready = 1'b0; cfg_abort = 1'b1;
    @(posedge ACLK); #1;
    cfg_abort = 1'b0;
    exp_q.delete();
    n_checks++;
    if ({m_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL abort_idle: {valid,busy}=%b, required 00", {m_valid, busy}); end
    n_checks++;
    if (blk_cnt !== 16'd0) begin n_fail++; $display("FAIL abort_blk_cnt: got %0d, required 0", blk_cnt); end
    m_ready = 1'b1; done_cnt = 0; activity = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge ACLK);
      if (done) done_cnt++;
      if (m_valid || buf_rd_en || busy) activity = 1'b1;
      @(posedge ACLK); #1;
    end
    n_checks++;
    if (done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done: %0d pulses, required 0", done_cnt); end
    n_checks++;
    if (activity !== 1'b0) begin n_fail++; $display("FAIL abort_quiet: activity=%b, required 0", activity); end
    // Fresh run after the abort
    push_expected(1);
    base = beats_seen; done_cnt = 0;
    start_run(16'd1);
    for (int cyc = 1; cyc <= 200 && done_cnt == 0; cyc++) begin
      @(negedge ACLK);
      if (done) done_cnt++;
      @(posedge ACLK); #1;
    end
    n_checks++;
    if (done_cnt != 1 || beats_seen - base != 64) begin
      n_fail++; $display("FAIL abort_rerun: done=%0d beats=%0d, required 1 and 64", done_cnt, beats_seen - base);
    end
    n_checks++;
    if (blk_cnt !== 16'd1) begin n_fail++; $display("FAIL abort_rerun_blk_cnt: got %0d, required 1", blk_cnt); end
  endtask

  task automatic test_slot_wrap();
    int         base, done_cnt, rd_n;
    logic [AW-1:0] want_addr;
    logic [5:0]    zero_slot;
    m_ready = 1'b1; done_cnt = 0; rd_n = 0; zero_slot = '0;
    push_expected(65);
    base = beats_seen;
    start_run(16'd65);
    for (int cyc = 1; cyc <= 5000 && done_cnt == 0; cyc++) begin
      @(negedge ACLK);
      if (buf_rd_en) begin
        if (rd_n >= 4096) begin
          want_addr = {zero_slot, zz[rd_n - 4096]};
          n_checks++;
          if (buf_rd_addr !== want_addr) begin
            n_fail++; $display("FAIL wrap_addr read %0d: got %h, required %h", rd_n, buf_rd_addr, want_addr);
          end
        end
        rd_n++;
      end
      if (done) done_cnt++;
      @(posedge ACLK); #1;
    end
    n_checks++;
    if (done_cnt != 1 || rd_n != 4160) begin
      n_fail++; $display("FAIL wrap_done: done=%0d reads=%0d, required 1 and 4160", done_cnt, rd_n);
    end
    n_checks++;
    if (beats_seen - base != 4160) begin n_fail++; $display("FAIL wrap_beats: got %0d, required 4160", beats_seen - base); end
    n_checks++;
    if (blk_cnt !== 16'd65) begin n_fail++; $display("FAIL wrap_blk_cnt: got %0d, required 65", blk_cnt); end
  endtask

  task automatic test_async_reset();
    int base, done_cnt;
    m_ready = 1'b1;
    push_expected(2);
    base = beats_seen;
    start_run(16'd2);
    for (int cyc = 0; cyc < 300 && (beats_seen - base) < 70; cyc++) begin
      @(posedge ACLK); #1;
    end
    n_checks++;
    if ({m_valid, blk_cnt} !== {1'b1, 16'd1}) begin
      n_fail++; $display("FAIL areset_pre: valid=%b blk_cnt=%0d, required 1 and 1", m_valid, blk_cnt);
    end
    // Assert reset between edges; outputs must clear before any clock edge.
    #2; ARESET = 1'b1; #1;
    n_checks++;
    if ({busy, done, buf_rd_en, m_valid, m_sob, m_last, m_eof} !== 7'd0) begin
      n_fail++; $display("FAIL areset_ctrl: got %b, required 0000000",
                         {busy, done, buf_rd_en, m_valid, m_sob, m_last, m_eof});
    end
    n_checks++;
    if ({blk_cnt, buf_rd_addr, m_coeff} !== '0) begin
      n_fail++; $display("FAIL areset_data: blk_cnt=%0d addr=%h coeff=%h, required 0", blk_cnt, buf_rd_addr, m_coeff);
    end
    @(posedge ACLK); #1;
    exp_q.delete();
    ARESET = 1'b0;
    repeat (2) begin @(posedge ACLK); #1; end
    push_expected(1);
    base = beats_seen; done_cnt = 0;
    start_run(16'd1);
    for (int cyc = 1; cyc <= 200 && done_cnt == 0; cyc++) begin
      @(negedge ACLK);
      if (done) done_cnt++;
      @(posedge ACLK); #1;
    end
    n_checks++;
    if (done_cnt != 1 || beats_seen - base != 64) begin
      n_fail++; $display("FAIL areset_rerun: done=%0d beats=%0d, required 1 and 64", done_cnt, beats_seen - base);
    end
    n_checks++;
    if (blk_cnt !== 16'd1) begin n_fail++; $display("FAIL areset_rerun_blk_cnt: got %0d, required 1", blk_cnt); end
  endtask

  initial begin
    build_zigzag();
    test_reset();
    test_single_block();
    test_zero_blocks();
    test_random_ready();
    test_abort();
    test_slot_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
